// File: rtl/rotate_n_nums.sv
// ============================================================================
// Module   : rotate_n_nums
// Purpose  : Rotates N packed lanes left or right by a requested step count,
//            with valid/ready handshakes on the input and output sides.
//            Define ROTATE_BARREL_EN to rotate in one shot at accept time;
//            leave it undefined for the default one-lane-per-cycle engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rotate_n_nums #(
  parameter int WIDTH = 8,
  parameter int N     = 3,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [AW-1:0]      in_amt,
  input  logic               in_dir,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic               busy
);

  localparam int c_dw = N * WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          r_state;
  logic [c_dw-1:0] r_buf;
  logic [AW-1:0]   r_cnt;
  logic            r_dir;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  // Single-lane step. Lane 0 sits in the least significant bits, so a left
  // step (lane i takes lane i+1) is a right shift of the packed vector.
  function automatic logic [c_dw-1:0] f_step(input logic [c_dw-1:0] d,
                                              input logic            dir);
    if (!dir) begin
      return {d[WIDTH-1:0], d[c_dw-1:WIDTH]};
    end
    return {d[c_dw-WIDTH-1:0], d[c_dw-1 -: WIDTH]};
  endfunction

  // Full rotation by amt mod N, computed per destination lane.
  function automatic logic [c_dw-1:0] f_barrel(input logic [c_dw-1:0] d,
                                                input logic [AW-1:0]   amt,
                                                input logic            dir);
    logic [c_dw-1:0] res;
    int              k;
    int              src;
    res = '0;
    k   = int'(amt) % N;
    for (int i = 0; i < N; i++) begin
      src = dir ? ((i - k + N) % N) : ((i + k) % N);
      res[i*WIDTH +: WIDTH] = d[src*WIDTH +: WIDTH];
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_dir       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_dir      <= in_dir;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifdef ROTATE_BARREL_EN
            r_buf       <= f_barrel(in_data, in_amt, in_dir);
            r_cnt       <= '0;
            r_state     <= DONE;
            r_out_valid <= 1'b1;
`else
            r_buf <= in_data;
            r_cnt <= in_amt;
            if (in_amt == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ROTATE;
            end
`endif
          end else begin
            // Ready rises one cycle after reset release and stays up in IDLE.
            r_in_ready <= 1'b1;
          end
        end

        ROTATE: begin
          r_buf <= f_step(r_buf, r_dir);
          r_cnt <= r_cnt - AW'(1);
          if (r_cnt == AW'(1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end

        DONE: begin
          // Completion edge never accepts; ready is seen in the next cycle.
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_data  = r_buf;

endmodule

`default_nettype wire
